// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift-register command sequencer.
// Mode encoding equals op encoding, so one enum serves both.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    function automatic logic is_shift(input op_t op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command channel into the sequencer: valid/ready handshake plus command fields.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    import shift_seq_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    op_t              cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_fill;
    logic             cmd_rot;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_rot, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_rot, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/shift_seq_cnt.sv
// Loadable down-counter tracking the shifts still owed to the current command.
module shift_seq_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_rem;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem <= '0;
        end else if (i_load) begin
            r_rem <= i_value;
        end else if (i_dec) begin
            r_rem <= r_rem - 1'b1;
        end
    end

    assign o_last = (r_rem == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving a universal shift register: parallel load or N shifts per command,
// stall-tolerant, with a one-cycle done pulse when the register holds the final value.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    shift_seq_ctrl_if.slave  cmd,
    input  logic             stall,
    input  logic [WIDTH-1:0] sr_q,
    output logic [1:0]       sr_mode,
    output logic             sr_s_left,
    output logic             sr_s_right,
    output logic [WIDTH-1:0] sr_data_in,
    output logic             so_valid,
    output logic             so_bit,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    op_t              r_mode;
    op_t              r_op;
    logic             r_fill;
    logic             r_rot;
    logic [WIDTH-1:0] r_data_in;

    logic w_accept;
    logic w_start_shift;
    logic w_shift_now;
    logic w_last;
    logic w_unused;

    assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;
    assign w_start_shift = w_accept && is_shift(cmd.cmd_op) && (cmd.cmd_count != '0);
    assign w_shift_now   = (r_state == ST_SHIFT) && (r_mode != OP_NOP);

    shift_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_start_shift),
        .i_value (cmd.cmd_count),
        .i_dec   (w_shift_now),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_mode    <= OP_NOP;
            r_op      <= OP_NOP;
            r_fill    <= 1'b0;
            r_rot     <= 1'b0;
            r_data_in <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (cmd.cmd_op == OP_LOAD) begin
                            r_data_in <= cmd.cmd_data;
                            r_mode    <= OP_LOAD;
                            r_state   <= ST_LOAD;
                        end else if (w_start_shift) begin
                            r_op    <= cmd.cmd_op;
                            r_fill  <= cmd.cmd_fill;
                            r_rot   <= cmd.cmd_rot;
                            r_mode  <= stall ? OP_NOP : cmd.cmd_op;
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    r_mode  <= OP_NOP;
                    r_state <= ST_DONE;
                end
                ST_SHIFT: begin
                    // A stalled cycle leaves the count alone, so stalls only stretch the command.
                    if (r_mode != OP_NOP && w_last) begin
                        r_mode  <= OP_NOP;
                        r_state <= ST_DONE;
                    end else begin
                        r_mode <= stall ? OP_NOP : r_op;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
    assign sr_mode       = r_mode;
    assign sr_data_in    = r_data_in;

    // Rotate feeds the bit leaving the register back into the opposite end.
    assign sr_s_left  = r_rot ? sr_q[0]       : r_fill;
    assign sr_s_right = r_rot ? sr_q[WIDTH-1] : r_fill;
    assign so_valid   = w_shift_now;
    assign so_bit     = (r_op == OP_SHL) ? sr_q[WIDTH-1] : sr_q[0];

    // Interior register bits are observed but never needed by the sequencer.
    assign w_unused = ^sr_q[WIDTH-2:1];

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench: sequencer paired with a behavioural shift register; spec-level model checked every cycle.
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall;
    logic [W-1:0] sr_q = '0;
    logic [1:0]   sr_mode;
    logic         sr_s_left, sr_s_right, so_valid, so_bit, busy, done;
    logic [W-1:0] sr_data_in;

    shift_seq_ctrl_if #(.WIDTH(W), .CNT_W(C)) cmd_if ();

    shift_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd_if),
        .stall      (stall),
        .sr_q       (sr_q),
        .sr_mode    (sr_mode),
        .sr_s_left  (sr_s_left),
        .sr_s_right (sr_s_right),
        .sr_data_in (sr_data_in),
        .so_valid   (so_valid),
        .so_bit     (so_bit),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Universal shift register controlled by the sequencer.
    always @(posedge clk) begin
        case (sr_mode)
            2'b01:   sr_q <= {sr_s_left, sr_q[W-1:1]};
            2'b10:   sr_q <= {sr_q[W-2:0], sr_s_right};
            2'b11:   sr_q <= sr_data_in;
            default: sr_q <= sr_q;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: expected register contents and per-cycle expectations for the current command.
    logic [W-1:0] m_q = '0;
    logic         exp_valid [64];
    logic         exp_bit   [64];
    logic [1:0]   exp_mode  [64];
    int           exp_done;
    int           acc_cyc;
    logic         track = 1'b0;
    logic [15:0]  obs_bits;
    int           obs_n;

    always @(negedge clk) begin
        if (track) begin
            automatic int c = cyc - acc_cyc;
            if (c >= 0 && c < 64) begin
                check("done",     done,      c == exp_done);
                check("busy",     busy,      (c >= 1) && (c <= exp_done));
                check("ready",    cmd_if.cmd_ready, c == 0);
                check("sr_mode",  sr_mode,   exp_mode[c]);
                check("so_valid", so_valid,  exp_valid[c]);
                if (exp_valid[c]) begin
                    check("so_bit", so_bit, exp_bit[c]);
                    if (obs_n < 16) obs_bits[obs_n] = so_bit;
                    obs_n++;
                end
                if (c == exp_done) check("sr_q_model", sr_q, m_q);
            end
        end
    end

    task automatic run_cmd(input op_t op, input logic [C-1:0] cnt, input logic fill,
                           input logic rot, input logic [W-1:0] data, input logic [31:0] stall_pat,
                           input int lit_done, input logic [W-1:0] lit_q, input logic [15:0] lit_bits);
        int           n, c;
        logic         b, sin, seen;
        for (int i = 0; i < 64; i++) begin
            exp_valid[i] = 1'b0;
            exp_bit[i]   = 1'b0;
            exp_mode[i]  = 2'b00;
        end
        if (op == OP_LOAD) begin
            exp_mode[1] = 2'b11;
            exp_done    = 2;
            m_q         = data;
        end else if (op == OP_NOP || cnt == 0) begin
            exp_done = 1;
        end else begin
            n = 0;
            c = 1;
            while (n < int'(cnt)) begin
                if (!stall_pat[c-1]) begin
                    b            = (op == OP_SHR) ? m_q[0] : m_q[W-1];
                    sin          = rot ? b : fill;
                    exp_valid[c] = 1'b1;
                    exp_bit[c]   = b;
                    exp_mode[c]  = op;
                    m_q          = (op == OP_SHR) ? {sin, m_q[W-1:1]} : {m_q[W-2:0], sin};
                    n++;
                end
                c++;
            end
            exp_done = c;
        end

        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_count = cnt;
        cmd_if.cmd_fill  = fill;
        cmd_if.cmd_rot   = rot;
        cmd_if.cmd_data  = data;
        stall            = stall_pat[0];
        acc_cyc          = cyc;
        obs_bits         = '0;
        obs_n            = 0;
        track            = 1'b1;
        seen             = 1'b0;

        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check("done_cycle", cyc - acc_cyc, lit_done);
                check("sr_q_lit",   sr_q, lit_q);
                check("bits_lit",   obs_bits, lit_bits);
                break;
            end
            @(posedge clk);
            #1;
            c     = cyc - acc_cyc;
            stall = (c < 32) ? stall_pat[c] : 1'b0;
            // Keep valid high with a conflicting command: it must be ignored while busy.
            cmd_if.cmd_op   = OP_LOAD;
            cmd_if.cmd_data = 8'h00;
        end
        check("done_seen", seen, 1'b1);

        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_NOP;
        stall            = 1'b0;
        track            = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        stall            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_NOP;
        cmd_if.cmd_count = '0;
        cmd_if.cmd_fill  = 1'b0;
        cmd_if.cmd_rot   = 1'b0;
        cmd_if.cmd_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mode",  sr_mode,          2'b00);
        check("rst_data",  sr_data_in,       8'h00);
        check("rst_done",  done,             1'b0);
        check("rst_busy",  busy,             1'b0);
        check("rst_ready", cmd_if.cmd_ready, 1'b1);

        //        op       cnt fill rot data   stall        done q      bits
        run_cmd(OP_LOAD, 4'd0, 0, 0, 8'hA5, 32'h0,  2, 8'hA5, 16'h0000);
        run_cmd(OP_SHR,  4'd3, 1, 0, 8'h00, 32'h0,  4, 8'hF4, 16'h0005);
        run_cmd(OP_LOAD, 4'd0, 0, 0, 8'h81, 32'h0,  2, 8'h81, 16'h0000);
        run_cmd(OP_SHL,  4'd8, 0, 1, 8'h00, 32'h0,  9, 8'h81, 16'h0081);
        run_cmd(OP_LOAD, 4'd0, 0, 0, 8'hFF, 32'h0,  2, 8'hFF, 16'h0000);
        run_cmd(OP_SHR,  4'd4, 0, 0, 8'h00, 32'h6,  7, 8'h0F, 16'h000F);
        run_cmd(OP_SHR,  4'd0, 1, 0, 8'h00, 32'h0,  1, 8'h0F, 16'h0000);
        run_cmd(OP_NOP,  4'd5, 1, 0, 8'h00, 32'h0,  1, 8'h0F, 16'h0000);
        run_cmd(OP_LOAD, 4'd0, 0, 0, 8'h00, 32'h0,  2, 8'h00, 16'h0000);
        run_cmd(OP_SHL,  4'd15, 1, 0, 8'h00, 32'h0, 16, 8'hFF, 16'h7F00);
        run_cmd(OP_LOAD, 4'd0, 0, 0, 8'h3C, 32'h0,  2, 8'h3C, 16'h0000);
        run_cmd(OP_SHR,  4'd5, 0, 1, 8'h00, 32'h1,  7, 8'hE1, 16'h001C);
        run_cmd(OP_LOAD, 4'd0, 0, 0, 8'h96, 32'h0,  2, 8'h96, 16'h0000);

        // Reset two shifts into SHL N=5 from 96: register keeps 58, no done pulse follows.
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_SHL;
        cmd_if.cmd_count = 4'd5;
        cmd_if.cmd_fill  = 1'b0;
        cmd_if.cmd_rot   = 1'b0;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_mode",  sr_mode,          2'b00);
        check("mid_rst_ready", cmd_if.cmd_ready, 1'b1);
        check("mid_rst_busy",  busy,             1'b0);
        check("mid_rst_done",  done,             1'b0);
        check("mid_rst_q",     sr_q,             8'h58);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_done", done, 1'b0);
            check("post_rst_q",    sr_q, 8'h58);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
